// File: rtl/pq_sorted_ctrl_if.sv
// Client-side handshake bundle for the sorted-array priority queue sequencer.
interface pq_sorted_ctrl_if #(
  parameter int KW = 16
);
  logic          enq_valid;
  logic [KW-1:0] enq_key;
  logic          enq_ready;
  logic          deq_valid;
  logic          deq_ready;
  logic          out_valid;
  logic [KW-1:0] out_key;

  modport master (
    output enq_valid, enq_key, deq_valid,
    input  enq_ready, deq_ready, out_valid, out_key
  );

  modport slave (
    input  enq_valid, enq_key, deq_valid,
    output enq_ready, deq_ready, out_valid, out_key
  );
endinterface

// File: rtl/pq_sorted_ctrl.sv
// Sorted-array priority queue sequencer: keeps keys ascending in mem[], one shift
// step per cycle, using an external index counter's registered output as scan index.
module pq_sorted_ctrl #(
  parameter int DEPTH = 16,
  parameter int KW    = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  pq_sorted_ctrl_if.slave q,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          cnt_rst,
  output logic          array_cnt_ld,
  output logic          array_cnt_clr,
  output logic          array_cnt_decr,
  output logic          array_cnt_inc,
  output logic          array_cnt_two,
  output logic [31:0]   array_cnt_out,
  output logic [31:0]   last_index,
  input  logic [31:0]   pointer_next
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_DEQ_SHIFT,
    S_ENQ_SCAN
  } state_t;

  state_t        state;
  logic [KW-1:0] mem [DEPTH];
  logic [KW-1:0] key_q;

  logic [IW-1:0] idx;
  logic          at_last;
  logic          at_zero;
  logic          gt;
  logic          deq_fire;
  logic          enq_fire;

  assign idx        = pointer_next[IW-1:0];
  assign at_last    = (pointer_next == last_index);
  assign at_zero    = (pointer_next == 32'd0);
  assign gt         = (mem[idx] > key_q);

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign busy       = (state != S_IDLE);
  assign last_index = empty ? '0 : (32'(count) - 32'd1);

  // Dequeue wins a simultaneous request, so enq_ready drops while a dequeue is offered.
  assign q.deq_ready = (state == S_IDLE) && !empty;
  assign q.enq_ready = (state == S_IDLE) && !full && !(q.deq_valid && !empty);
  assign deq_fire    = q.deq_valid && q.deq_ready;
  assign enq_fire    = q.enq_valid && q.enq_ready;

  assign array_cnt_out = (state == S_IDLE) ? last_index : pointer_next;
  assign array_cnt_two = 1'b0;

  always_comb begin
    cnt_rst        = 1'b0;
    array_cnt_ld   = 1'b0;
    array_cnt_clr  = 1'b0;
    array_cnt_decr = 1'b0;
    array_cnt_inc  = 1'b0;
    case (state)
      S_INIT: cnt_rst = 1'b1;
      S_IDLE: begin
        if (deq_fire) begin
          if (count == CW'(1)) array_cnt_clr = 1'b1;
          else                 array_cnt_ld  = 1'b1;
        end
      end
      S_DEQ_SHIFT: begin
        if (at_last) array_cnt_clr = 1'b1;
        else         array_cnt_inc = 1'b1;
      end
      S_ENQ_SCAN: begin
        if (gt && !at_zero) array_cnt_decr = 1'b1;
        else                array_cnt_clr  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      count       <= '0;
      q.out_valid <= 1'b0;
      q.out_key   <= '0;
      key_q       <= '0;
    end else begin
      q.out_valid <= 1'b0;
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (deq_fire) begin
            q.out_valid <= 1'b1;
            q.out_key   <= mem[0];
            if (count == CW'(1)) count <= '0;
            else                 state <= S_DEQ_SHIFT;
          end else if (enq_fire) begin
            key_q <= q.enq_key;
            if (empty) count <= CW'(1);
            else       state <= S_ENQ_SCAN;
          end
        end
        S_DEQ_SHIFT: begin
          if (at_last) begin
            count <= count - CW'(1);
            state <= S_IDLE;
          end
        end
        S_ENQ_SCAN: begin
          if (!gt || at_zero) begin
            count <= count + CW'(1);
            state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Storage is deliberately unreset; count alone marks which entries are valid.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (enq_fire && empty) mem[0] <= q.enq_key;
      end
      S_DEQ_SHIFT: mem[idx - IW'(1)] <= mem[idx];
      S_ENQ_SCAN: begin
        if (gt) begin
          mem[idx + IW'(1)] <= mem[idx];
          if (at_zero) mem[0] <= key_q;
        end else begin
          mem[idx + IW'(1)] <= key_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pq_sorted_ctrl.sv
// Directed bench for pq_sorted_ctrl with a behavioural model of the index counter.
module tb_pq_sorted_ctrl;
  localparam int DEPTH = 16;
  localparam int KW    = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OP_ENQ = 0;
  localparam int OP_DEQ = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pq_sorted_ctrl_if #(.KW(KW)) q ();

  logic [CW-1:0] count;
  logic full, empty, busy;
  logic cnt_rst, cnt_ld, cnt_clr, cnt_decr, cnt_inc, cnt_two;
  logic [31:0] cnt_out, last_index;
  logic [31:0] ptr = '0;

  pq_sorted_ctrl #(.DEPTH(DEPTH), .KW(KW), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .q              (q),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .busy           (busy),
    .cnt_rst        (cnt_rst),
    .array_cnt_ld   (cnt_ld),
    .array_cnt_clr  (cnt_clr),
    .array_cnt_decr (cnt_decr),
    .array_cnt_inc  (cnt_inc),
    .array_cnt_two  (cnt_two),
    .array_cnt_out  (cnt_out),
    .last_index     (last_index),
    .pointer_next   (ptr)
  );

  // Index counter: synchronous clear, load-1, inc/dec of the fed index, else track it.
  always @(posedge clk) begin
    if (cnt_rst)       ptr <= '0;
    else if (cnt_clr)  ptr <= '0;
    else if (cnt_ld)   ptr <= 32'd1;
    else if (cnt_inc)  ptr <= cnt_out + 32'd1;
    else if (cnt_decr) ptr <= cnt_out - 32'd1;
    else               ptr <= cnt_out;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("strobe_onehot", 64'($countones({cnt_rst, cnt_ld, cnt_clr, cnt_decr, cnt_inc, cnt_two}) > 1), 64'd0);
    chk("cnt_two_zero", 64'(cnt_two), 64'd0);
  end

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Issue one request at a negedge, then follow the operation to its end.
  task automatic do_op(input int op, input logic [KW-1:0] key,
                       output logic [KW-1:0] got, output int nbusy, output int pulses);
    int t;
    got = '0; nbusy = 0; pulses = 0; t = 0;
    if (op == OP_ENQ) begin
      q.enq_valid = 1'b1;
      q.enq_key   = key;
      #1 chk("enq_ready", 64'(q.enq_ready), 64'd1);
    end else begin
      q.deq_valid = 1'b1;
      #1 chk("deq_ready", 64'(q.deq_ready), 64'd1);
    end
    @(negedge clk);
    q.enq_valid = 1'b0;
    q.deq_valid = 1'b0;
    while (t < 200) begin
      if (q.out_valid) begin
        pulses++;
        got = q.out_key;
      end
      if (!busy) break;
      nbusy++;
      t++;
      @(negedge clk);
    end
    if (busy) chk("op_timeout", 64'd1, 64'd0);
  endtask

  typedef struct {
    int            op;
    logic [KW-1:0] key;
    logic [KW-1:0] exp_key;
    int            exp_count;
    int            exp_busy;
  } vec_t;

  vec_t vt [22];

  function automatic vec_t mk(input int op, input logic [KW-1:0] key, input int c, input int b);
    vec_t v;
    v.op = op; v.key = key; v.exp_key = key; v.exp_count = c; v.exp_busy = b;
    return v;
  endfunction

  logic [KW-1:0] got;
  int nb, np;

  initial begin
    q.enq_valid = 1'b0;
    q.deq_valid = 1'b0;
    q.enq_key   = '0;

    vt[0]  = mk(OP_ENQ, 16'd30, 1, 0);
    vt[1]  = mk(OP_ENQ, 16'd10, 2, 1);
    vt[2]  = mk(OP_ENQ, 16'd20, 3, 2);
    vt[3]  = mk(OP_DEQ, 16'd10, 2, 2);
    vt[4]  = mk(OP_DEQ, 16'd20, 1, 1);
    vt[5]  = mk(OP_DEQ, 16'd30, 0, 0);
    vt[6]  = mk(OP_ENQ, 16'd5,  1, 0);
    vt[7]  = mk(OP_ENQ, 16'd7,  2, 1);
    vt[8]  = mk(OP_ENQ, 16'd9,  3, 1);
    vt[9]  = mk(OP_ENQ, 16'd1,  4, 3);
    vt[10] = mk(OP_DEQ, 16'd1,  3, 3);
    vt[11] = mk(OP_DEQ, 16'd5,  2, 2);
    vt[12] = mk(OP_DEQ, 16'd7,  1, 1);
    vt[13] = mk(OP_DEQ, 16'd9,  0, 0);
    vt[14] = mk(OP_ENQ, 16'd8,  1, 0);
    vt[15] = mk(OP_ENQ, 16'd8,  2, 1);
    vt[16] = mk(OP_DEQ, 16'd8,  1, 1);
    vt[17] = mk(OP_DEQ, 16'd8,  0, 0);
    vt[18] = mk(OP_ENQ, 16'hFFFF, 1, 0);
    vt[19] = mk(OP_ENQ, 16'd0,  2, 1);
    vt[20] = mk(OP_DEQ, 16'd0,  1, 1);
    vt[21] = mk(OP_DEQ, 16'hFFFF, 0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(q.out_valid), 64'd0);
    chk("rst_out_key", 64'(q.out_key), 64'd0);
    chk("rst_cnt_rst", 64'(cnt_rst), 64'd1);
    rst = 1'b1;
    #1 chk("init_cnt_rst", 64'(cnt_rst), 64'd1);
    @(negedge clk);
    chk("idle_cnt_rst", 64'(cnt_rst), 64'd0);
    chk("idle_empty", 64'(empty), 64'd1);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_enq_ready", 64'(q.enq_ready), 64'd1);
    chk("idle_deq_ready", 64'(q.deq_ready), 64'd0);
    chk("idle_last_index", 64'(last_index), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 22; i++) begin
      wait_idle();
      do_op(vt[i].op, vt[i].key, got, nb, np);
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vt[i].exp_count));
      chk($sformatf("v%0d_busy", i), 64'(nb), 64'(vt[i].exp_busy));
      chk($sformatf("v%0d_last", i), 64'(last_index),
          64'(vt[i].exp_count == 0 ? 0 : vt[i].exp_count - 1));
      if (vt[i].op == OP_DEQ) begin
        chk($sformatf("v%0d_key", i), 64'(got), 64'(vt[i].exp_key));
        chk($sformatf("v%0d_pulses", i), 64'(np), 64'd1);
      end else begin
        chk($sformatf("v%0d_pulses", i), 64'(np), 64'd0);
      end
    end

    // Fill to DEPTH, then push against full
    for (int i = 0; i < DEPTH; i++) begin
      wait_idle();
      do_op(OP_ENQ, KW'(i), got, nb, np);
      chk($sformatf("fill%0d_count", i), 64'(count), 64'(i + 1));
      chk($sformatf("fill%0d_busy", i), 64'(nb), 64'(i == 0 ? 0 : 1));
    end
    chk("full_flag", 64'(full), 64'd1);
    q.enq_valid = 1'b1;
    q.enq_key   = 16'd99;
    for (int i = 0; i < 5; i++) begin
      #1 chk("full_enq_ready", 64'(q.enq_ready), 64'd0);
      @(negedge clk);
    end
    q.enq_valid = 1'b0;
    chk("full_hold_count", 64'(count), 64'(DEPTH));
    do_op(OP_DEQ, '0, got, nb, np);
    chk("full_deq_key", 64'(got), 64'd0);
    chk("full_deq_busy", 64'(nb), 64'(DEPTH - 1));
    chk("after_full_enq_ready", 64'(q.enq_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) begin
      do_op(OP_DEQ, '0, got, nb, np);
      chk($sformatf("drain%0d_key", i), 64'(got), 64'(i));
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Simultaneous enqueue and dequeue: dequeue wins
    do_op(OP_ENQ, 16'd4, got, nb, np);
    q.enq_valid = 1'b1;
    q.enq_key   = 16'd6;
    q.deq_valid = 1'b1;
    #1;
    chk("sim_enq_ready", 64'(q.enq_ready), 64'd0);
    chk("sim_deq_ready", 64'(q.deq_ready), 64'd1);
    @(negedge clk);
    q.deq_valid = 1'b0;
    chk("sim_out_valid", 64'(q.out_valid), 64'd1);
    chk("sim_out_key", 64'(q.out_key), 64'd4);
    chk("sim_count0", 64'(count), 64'd0);
    #1 chk("sim_enq_ready2", 64'(q.enq_ready), 64'd1);
    @(negedge clk);
    q.enq_valid = 1'b0;
    chk("sim_count1", 64'(count), 64'd1);
    do_op(OP_DEQ, '0, got, nb, np);
    chk("sim_deq_key", 64'(got), 64'd6);

    // Reset in the middle of a dequeue shift
    do_op(OP_ENQ, 16'd1, got, nb, np);
    do_op(OP_ENQ, 16'd2, got, nb, np);
    do_op(OP_ENQ, 16'd3, got, nb, np);
    q.deq_valid = 1'b1;
    @(negedge clk);
    q.deq_valid = 1'b0;
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(q.out_valid), 64'd0);
    chk("mid_rst_out_key", 64'(q.out_key), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_cnt_rst", 64'(cnt_rst), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_init_cnt_rst", 64'(cnt_rst), 64'd1);
    @(negedge clk);
    chk("mid_idle_cnt_rst", 64'(cnt_rst), 64'd0);
    chk("mid_idle_busy", 64'(busy), 64'd0);
    do_op(OP_ENQ, 16'd42, got, nb, np);
    do_op(OP_DEQ, '0, got, nb, np);
    chk("post_rst_key", 64'(got), 64'd42);
    chk("post_rst_empty", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
